lfo_delay_mod: RTL and testbench

//  Consumer end of the LFO generator: LFO word + new-value strobe modulate the read tap of a circular audio delay line.

---
 rtl/lfo_delay_mod.sv | 161 ++++++++++++++++
 tb/tb_lfo_delay_mod.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfo_delay_mod.sv
// lfo_delay_mod: LFO-modulated fractional delay line with linear interpolation (vibrato/chorus core).
// Optional DRY_WET_MIX_EN blends the dry input 50/50 with the delayed sample (chorus).
`default_nettype none

module lfo_delay_mod #(
    parameter int ADDR_W     = 10,
    parameter int BASE_DELAY = 480,
    parameter int DEPTH      = 240,
    parameter int FRAC_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] sampleIn,
    input  logic               sampleValid,
    input  logic signed [15:0] lfoIn,
    input  logic               lfoNew,
    output logic signed [15:0] sampleOut,
    output logic               outValid,
    output logic               busy,
    output logic               overrun
);

    localparam int BUF_LEN = 2 ** ADDR_W;
    localparam int PW      = 16 + ADDR_W + 1;
    localparam int MW      = 18 + FRAC_W;
    localparam logic signed [PW-1:0] DEPTH_S  = PW'(DEPTH);
    localparam logic signed [31:0]   BASE_FIX = 32'(BASE_DELAY * (2 ** FRAC_W));
    localparam logic signed [31:0]   D_MAX    = 32'(BUF_LEN - 2);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_WRITE, S_RDA, S_RDB, S_MIX, S_OUT
    } state_t;

    state_t state;

    logic signed [15:0]       mem [BUF_LEN];
    logic [ADDR_W-1:0]        wr_ptr, wp, clr_cnt, d_lat, d_w, rd_addr;
    logic [FRAC_W-1:0]        f_lat, f_w;
    logic signed [15:0]       lfo_reg, dry, a_smp, b_smp, wet, res, res_w;
    logic signed [31:0]       delay_fix, d_int;
    logic signed [PW-1:0]     prod;
    logic signed [16:0]       diff;
    logic signed [MW-1:0]     scaled, wet_full;
    logic                     out_pend;

    function automatic logic signed [15:0] sat16(input logic signed [MW-1:0] x);
        if (x > MW'(32767))
            return 16'sh7FFF;
        else if (x < -MW'(32768))
            return 16'sh8000;
        else
            return x[15:0];
    endfunction

    always_comb begin
        prod  = $signed({{(PW-16){lfo_reg[15]}}, lfo_reg}) * DEPTH_S;
        d_int = delay_fix >>> FRAC_W;
        if (d_int < 0)
            d_w = '0;
        else if (d_int > D_MAX)
            d_w = ADDR_W'(D_MAX);
        else
            d_w = d_int[ADDR_W-1:0];
        f_w = delay_fix[FRAC_W-1:0];
        // Tap b sits one sample further back than tap a.
        rd_addr  = wp - d_lat - ((state == S_RDB) ? ADDR_W'(1) : ADDR_W'(0));
        diff     = 17'(b_smp) - 17'(a_smp);
        scaled   = MW'(diff) * MW'($signed({1'b0, f_lat}));
        wet_full = MW'(a_smp) + (scaled >>> FRAC_W);
`ifdef DRY_WET_MIX_EN
        // Halved sum of two 16-bit values always fits, so no clipping is needed.
        res_w = 16'((17'(dry) + 17'(wet)) >>> 1);
`else
        res_w = wet;
`endif
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset && state == S_CLEAR)
            mem[clr_cnt] <= '0;
        else if (!reset && state == S_WRITE)
            mem[wr_ptr] <= dry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            wr_ptr    <= '0;
            wp        <= '0;
            lfo_reg   <= '0;
            delay_fix <= BASE_FIX;
            d_lat     <= '0;
            f_lat     <= '0;
            dry       <= '0;
            a_smp     <= '0;
            b_smp     <= '0;
            wet       <= '0;
            res       <= '0;
            out_pend  <= 1'b0;
            sampleOut <= '0;
            outValid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            outValid  <= 1'b0;
            out_pend  <= 1'b0;
            overrun   <= sampleValid && (state != S_IDLE);
            delay_fix <= BASE_FIX + 32'(prod >>> (15 - FRAC_W));
            if (lfoNew)
                lfo_reg <= lfoIn;
            // Result is published one cycle after OUT, giving the 6-clock accept-to-outValid latency.
            if (out_pend) begin
                sampleOut <= res;
                outValid  <= 1'b1;
            end
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt)
                        state <= S_IDLE;
                end
                S_IDLE: begin
                    if (sampleValid) begin
                        dry   <= sampleIn;
                        d_lat <= d_w;
                        f_lat <= f_w;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wp     <= wr_ptr;
                    wr_ptr <= wr_ptr + 1'b1;
                    state  <= S_RDA;
                end
                S_RDA: begin
                    a_smp <= mem[rd_addr];
                    state <= S_RDB;
                end
                S_RDB: begin
                    b_smp <= mem[rd_addr];
                    state <= S_MIX;
                end
                S_MIX: begin
                    wet   <= sat16(wet_full);
                    state <= S_OUT;
                end
                S_OUT: begin
                    res      <= res_w;
                    out_pend <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lfo_delay_mod.sv
// tb_lfo_delay_mod: randomized self-checking bench against a sample-history reference model.
`default_nettype none

module tb_lfo_delay_mod;

    localparam int BASE_DELAY = 480;
    localparam int DEPTH      = 240;
    localparam int FRAC_W     = 8;
    localparam int BUF_LEN    = 1024;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] sampleIn;
    logic               sampleValid;
    logic signed [15:0] lfoIn;
    logic               lfoNew;
    logic signed [15:0] sampleOut;
    logic               outValid;
    logic               busy;
    logic               overrun;

    int checks   = 0;
    int failures = 0;
    int hist[$];
    int lfo_m    = 0;
    int outs[730];

    lfo_delay_mod dut (
        .clk         (clk),
        .reset       (reset),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .lfoIn       (lfoIn),
        .lfoNew      (lfoNew),
        .sampleOut   (sampleOut),
        .outValid    (outValid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Output for the next accepted sample, computed from the full input history.
    function automatic int model_next(input int s);
        longint fix, dd;
        int d, f, n, a, b, wet;
        fix = longint'(BASE_DELAY) * (1 << FRAC_W) + ((longint'(lfo_m) * DEPTH) >>> (15 - FRAC_W));
        dd  = fix >>> FRAC_W;
        f   = int'(fix - (dd << FRAC_W));
        d   = (dd < 0) ? 0 : (dd > BUF_LEN - 2) ? BUF_LEN - 2 : int'(dd);
        hist.push_back(s);
        n   = hist.size() - 1;
        a   = (n - d >= 0) ? hist[n - d] : 0;
        b   = (n - d - 1 >= 0) ? hist[n - d - 1] : 0;
        wet = sat(a + (((b - a) * f) >>> FRAC_W));
`ifdef DRY_WET_MIX_EN
        return sat((s + wet) >>> 1);
`else
        return wet;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_clear(input string tag);
        int cnt = 0;
        int bad = 0;
        while (busy && cnt < 3000) begin
            if (outValid || sampleOut != 0) bad++;
            cnt++;
            tick();
        end
        check({tag, "_busy_len"}, cnt, 1024);
        check({tag, "_quiet"}, bad, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        check("rst_out", int'(sampleOut), 0);
        check("rst_valid", int'(outValid), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        hist.delete();
        lfo_m = 0;
        measure_clear("clr");
    endtask

    task automatic set_lfo(input int v);
        lfoIn  = 16'(v);
        lfoNew = 1'b1;
        tick();
        lfoNew = 1'b0;
        lfo_m  = v;
        repeat (2) tick();
    endtask

    task automatic send(input int s, input bit do_lfo, input int lfo_val, input string tag, output int got);
        int exp_v;
        int lat = 0;
        exp_v       = model_next(s);
        sampleIn    = 16'(s);
        sampleValid = 1'b1;
        if (do_lfo) begin
            lfoIn  = 16'(lfo_val);
            lfoNew = 1'b1;
        end
        tick();
        sampleValid = 1'b0;
        lfoNew      = 1'b0;
        if (do_lfo) lfo_m = lfo_val;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (outValid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 6);
        check({tag, "_out"}, int'(sampleOut), exp_v);
        got = int'(sampleOut);
    endtask

    task automatic impulse_run(input int lfo_v, input string tag);
        do_reset();
        set_lfo(lfo_v);
        for (int k = 0; k < 730; k++)
            send((k == 0) ? 16384 : 0, 1'b0, 0, tag, outs[k]);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, exp_v, pulses, lat, val;
        reset       = 1'b1;
        sampleIn    = '0;
        sampleValid = 1'b0;
        lfoIn       = '0;
        lfoNew      = 1'b0;
        tick();

        do_reset();

        impulse_run(0, "imp0");
`ifdef DRY_WET_MIX_EN
        check("imp0_k0", outs[0], 8192);
        check("imp0_k480", outs[480], 8192);
`else
        check("imp0_k0", outs[0], 0);
        check("imp0_k480", outs[480], 16384);
        check("imp0_k481", outs[481], 0);
`endif

        impulse_run(32767, "impmax");
`ifndef DRY_WET_MIX_EN
        check("impmax_k719", outs[719], 128);
        check("impmax_k720", outs[720], 16256);
        check("impmax_k718", outs[718], 0);
`endif

        impulse_run(-32768, "impmin");
`ifndef DRY_WET_MIX_EN
        check("impmin_k240", outs[240], 16384);
        check("impmin_k241", outs[241], 0);
`endif

        do_reset();
        for (int k = 0; k < 500; k++) send(32767, 1'b0, 0, "dc", got);
        check("dc_last", got, 32767);

        do_reset();
        for (int i = 0; i < 1100; i++) begin
            if (i % 97 == 50)
                set_lfo(int'($urandom_range(0, 65535)) - 32768);
            send(int'($urandom_range(0, 65535)) - 32768, (i % 40 == 0),
                 int'($urandom_range(0, 65535)) - 32768, "rnd", got);
        end

        // Back-to-back strobes: the second one is dropped.
        exp_v       = model_next(1000);
        sampleIn    = 16'sd1000;
        sampleValid = 1'b1;
        tick();
        check("ovr_first", int'(overrun), 0);
        sampleIn = 16'sd2000;
        tick();
        sampleValid = 1'b0;
        check("ovr_pulse", int'(overrun), 1);
        pulses = 0;
        lat    = 0;
        val    = 0;
        for (int k = 2; k <= 14; k++) begin
            tick();
            if (k == 2) check("ovr_clear", int'(overrun), 0);
            if (outValid) begin
                pulses++;
                lat = k;
                val = int'(sampleOut);
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_lat", lat, 6);
        check("ovr_out", val, exp_v);

        // Reset while the sample sits in RDB aborts it.
        sampleIn    = 16'sd3000;
        sampleValid = 1'b1;
        tick();
        sampleValid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hist.delete();
        lfo_m = 0;
        check("abort_valid", int'(outValid), 0);
        measure_clear("abort");
        send(1234, 1'b0, 0, "post", got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
